// File: rtl/spi_frame_writer_pkg.sv
// Shared definitions for the SPI frame writer: pixel word layout, default
// frame geometry and the receive FSM state encoding.
package spi_frame_writer_pkg;

    // Pixel word width and RGB4444x field positions ([3:0] unused).
    localparam int DATA_W = 16;
    localparam int RED_MSB = 15;
    localparam int RED_LSB = 12;
    localparam int GRN_MSB = 11;
    localparam int GRN_LSB = 8;
    localparam int BLU_MSB = 7;
    localparam int BLU_LSB = 4;

    // Default frame geometry: 64x32 panel, one word per pixel.
    localparam int DEFAULT_PIXELS = 2048;
    localparam int DEFAULT_ADDR_W = 11;

    // Default synchroniser depth for the asynchronous SPI pins.
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Receive FSM state codes, shared with the scan controller.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } state_e;

endpackage

// File: rtl/spi_frame_writer_edge_sync.sv
// N-stage synchroniser for one asynchronous input, with single-cycle rise
// and fall pulses derived against one extra registered copy.
module spi_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchroniser chain and keep a delayed copy of its output.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // Reset to the pin's idle level so leaving reset never looks like an edge.
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            // NOTE: flops take non-blocking assignments so every stage samples the
            // value from before this edge; blocking here would collapse the chain.
            sync_q <= (sync_q << 1) | STAGES'(async_i);
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_writer.sv
// SPI (mode 0, MSB first) receiver feeding the HUB75 double-buffered pixel
// RAM. Oversamples the SPI pins in the pixel_clk domain, assembles 16-bit
// pixel words, writes them sequentially and flips banks only at the display's
// frame boundary.
module spi_frame_writer
    import spi_frame_writer_pkg::*;
#(
    parameter int PIXELS      = DEFAULT_PIXELS,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    input  logic              frame_start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              flip_pending,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    // Synchronised SPI pins.
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ss_lvl, ss_rise, ss_fall;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i  (pixel_clk),
        .reset_i(reset),
        .async_i(spi_clk),
        .level_o(sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i  (pixel_clk),
        .reset_i(reset),
        .async_i(spi_mosi),
        .level_o(mosi_lvl),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk_i  (pixel_clk),
        .reset_i(reset),
        .async_i(spi_ss_n),
        .level_o(ss_lvl),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    // Synchroniser outputs this block has no use for.
    logic sync_unused;
    assign sync_unused = &{sclk_lvl, sclk_fall, mosi_rise, mosi_fall, ss_lvl};

    // Receiver and frame state.
    state_e              state_q;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                word_ready_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q;
    logic                rd_bank_q;
    logic                flip_pending_q;
    logic                overrun_q;

    // Next values for the shifter, bit counter and wrapping write address.
    always_comb begin
        shift_d   = {shift_q[DATA_W-2:0], mosi_lvl};
        bit_cnt_d = bit_cnt_q + 4'd1;
        wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
    end

    // Receive FSM, write strobe, address counter and bank flip handshake.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            word_ready_q   <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            rd_bank_q      <= 1'b0;
            flip_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            word_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // A new transaction always starts a fresh frame at address 0.
                    if (ss_fall) begin
                        state_q   <= ST_RECEIVE;
                        bit_cnt_q <= '0;
                        wr_addr_q <= '0;
                        overrun_q <= 1'b0;
                    end
                end
                ST_RECEIVE: begin
                    // Deselect wins over a coincident clock edge; any partial word is dropped.
                    if (ss_rise) begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                    end else if (sclk_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_d;
                        if (bit_cnt_q == 4'hF) begin
                            word_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Completed word: write it, or drop it while the finished frame awaits display.
            if (word_ready_q) begin
                if (flip_pending_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= shift_q;
                end
            end

            // Advance after each strobe; writing the last pixel completes the frame.
            if (wr_en_q) begin
                wr_addr_q <= wr_addr_d;
                if (wr_addr_q == LAST_ADDR) begin
                    flip_pending_q <= 1'b1;
                end
            end

            // Registered pending flag decides, so a frame finishing on this edge waits one frame.
            if (frame_start && flip_pending_q) begin
                rd_bank_q      <= ~rd_bank_q;
                flip_pending_q <= 1'b0;
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign rd_bank      = rd_bank_q;
    assign wr_bank      = ~rd_bank_q;
    assign flip_pending = flip_pending_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_spi_frame_writer.sv
// Directed bench for spi_frame_writer, using a 32-word frame so full-frame
// scenarios stay short. SPI runs at pixel_clk/4 (the fastest allowed rate).
module tb_spi_frame_writer;

    localparam int TB_PIXELS = 32;
    localparam int TB_ADDR_W = 5;
    localparam int LATENCY   = 4;  // SYNC_STAGES + 2

    logic                 pixel_clk = 1'b0;
    logic                 reset;
    logic                 spi_clk;
    logic                 spi_mosi;
    logic                 spi_ss_n;
    logic                 frame_start;
    logic                 wr_en;
    logic [TB_ADDR_W-1:0] wr_addr;
    logic [15:0]          wr_data;
    logic                 wr_bank;
    logic                 rd_bank;
    logic                 flip_pending;
    logic                 overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rise_cyc = 0;

    typedef struct {
        logic [TB_ADDR_W-1:0] addr;
        logic [15:0]          data;
        logic                 bank;
        int                   cyc;
    } wr_t;

    wr_t wq[$];

    spi_frame_writer #(
        .PIXELS     (TB_PIXELS),
        .ADDR_W     (TB_ADDR_W),
        .SYNC_STAGES(2)
    ) dut (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_ss_n    (spi_ss_n),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_bank     (wr_bank),
        .rd_bank     (rd_bank),
        .flip_pending(flip_pending),
        .overrun     (overrun)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) cyc++;

    // Record every RAM write strobe, sampled mid-cycle.
    always @(negedge pixel_clk) begin
        if (wr_en === 1'b1) begin
            wq.push_back('{addr: wr_addr, data: wr_data, bank: wr_bank, cyc: cyc});
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge pixel_clk);
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        wait_cycles(2);
        spi_clk = 1'b1;
        last_rise_cyc = cyc;
        wait_cycles(2);
        spi_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int nbits);
        for (int i = 15; i > 15 - nbits; i--) spi_bit(w[i]);
    endtask

    task automatic ss_begin();
        spi_ss_n = 1'b0;
        wait_cycles(4);
    endtask

    task automatic ss_end();
        wait_cycles(4);
        spi_ss_n = 1'b1;
        wait_cycles(6);
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        wait_cycles(1);
        frame_start = 1'b0;
        wait_cycles(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1; frame_start = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        n_checks++; if (wr_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0h expected 0", wr_addr); end
        n_checks++; if (wr_data !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0000", wr_data); end
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL reset_rd_bank: got %b expected 0", rd_bank); end
        n_checks++; if (wr_bank !== 1'b1) begin n_fail++; $display("FAIL reset_wr_bank: got %b expected 1", wr_bank); end
        n_checks++; if (flip_pending !== 1'b0) begin n_fail++; $display("FAIL reset_flip_pending: got %b expected 0", flip_pending); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_single_word();
        wq.delete();
        ss_begin();
        send_bits(16'hF0A5, 16);
        ss_end();
        n_checks++; if (wq.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d writes expected 1", wq.size()); end
        if (wq.size() >= 1) begin
            n_checks++; if (wq[0].addr !== 5'd0) begin n_fail++; $display("FAIL single_addr: got %0h expected 0", wq[0].addr); end
            n_checks++; if (wq[0].data !== 16'hF0A5) begin n_fail++; $display("FAIL single_data: got %h expected f0a5", wq[0].data); end
            n_checks++; if (wq[0].bank !== 1'b1) begin n_fail++; $display("FAIL single_bank: got %b expected 1", wq[0].bank); end
            n_checks++; if (wq[0].cyc - last_rise_cyc != LATENCY) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", wq[0].cyc - last_rise_cyc, LATENCY); end
        end
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL single_rd_bank: got %b expected 0", rd_bank); end
    endtask

    task automatic test_full_frame();
        wq.delete();
        ss_begin();
        for (int i = 0; i < TB_PIXELS; i++) send_bits(16'(i * 16'h0801), 16);
        ss_end();
        n_checks++; if (wq.size() != TB_PIXELS) begin n_fail++; $display("FAIL frame_count: got %0d writes expected %0d", wq.size(), TB_PIXELS); end
        for (int i = 0; i < wq.size() && i < TB_PIXELS; i++) begin
            n_checks++; if (wq[i].addr !== 5'(i)) begin n_fail++; $display("FAIL frame_addr[%0d]: got %0h expected %0h", i, wq[i].addr, i); end
            n_checks++; if (wq[i].data !== 16'(i * 16'h0801)) begin n_fail++; $display("FAIL frame_data[%0d]: got %h expected %h", i, wq[i].data, 16'(i * 16'h0801)); end
            n_checks++; if (wq[i].bank !== 1'b1) begin n_fail++; $display("FAIL frame_bank[%0d]: got %b expected 1", i, wq[i].bank); end
        end
        n_checks++; if (flip_pending !== 1'b1) begin n_fail++; $display("FAIL frame_pending: got %b expected 1", flip_pending); end
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL frame_rd_before_flip: got %b expected 0", rd_bank); end
        n_checks++; if (wr_addr !== 5'd0) begin n_fail++; $display("FAIL frame_addr_wrap: got %0h expected 0", wr_addr); end
        pulse_frame_start();
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL flip_rd_bank: got %b expected 1", rd_bank); end
        n_checks++; if (wr_bank !== 1'b0) begin n_fail++; $display("FAIL flip_wr_bank: got %b expected 0", wr_bank); end
        n_checks++; if (flip_pending !== 1'b0) begin n_fail++; $display("FAIL flip_pending_clear: got %b expected 0", flip_pending); end
    endtask

    task automatic test_partial_word();
        // frame_start with nothing pending must leave the banks alone.
        pulse_frame_start();
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL noflip_rd_bank: got %b expected 1", rd_bank); end
        n_checks++; if (wr_bank !== 1'b0) begin n_fail++; $display("FAIL noflip_wr_bank: got %b expected 0", wr_bank); end
        wq.delete();
        ss_begin();
        send_bits(16'hFF80, 9);
        ss_end();
        ss_begin();
        send_bits(16'h1234, 16);
        ss_end();
        n_checks++; if (wq.size() != 1) begin n_fail++; $display("FAIL partial_count: got %0d writes expected 1", wq.size()); end
        if (wq.size() >= 1) begin
            n_checks++; if (wq[0].addr !== 5'd0) begin n_fail++; $display("FAIL partial_addr: got %0h expected 0", wq[0].addr); end
            n_checks++; if (wq[0].data !== 16'h1234) begin n_fail++; $display("FAIL partial_data: got %h expected 1234", wq[0].data); end
            n_checks++; if (wq[0].bank !== 1'b0) begin n_fail++; $display("FAIL partial_bank: got %b expected 0", wq[0].bank); end
        end
    endtask

    task automatic test_overrun();
        wq.delete();
        ss_begin();
        for (int i = 0; i < TB_PIXELS; i++) send_bits(16'hA000 + 16'(i), 16);
        send_bits(16'hBEEF, 16);
        wait_cycles(6);
        n_checks++; if (wq.size() != TB_PIXELS) begin n_fail++; $display("FAIL overrun_count: got %0d writes expected %0d", wq.size(), TB_PIXELS); end
        if (wq.size() >= 1) begin
            n_checks++; if (wq[wq.size()-1].data !== 16'hA01F) begin n_fail++; $display("FAIL overrun_last_data: got %h expected a01f", wq[wq.size()-1].data); end
        end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        n_checks++; if (wr_addr !== 5'd0) begin n_fail++; $display("FAIL overrun_addr: got %0h expected 0", wr_addr); end
        n_checks++; if (flip_pending !== 1'b1) begin n_fail++; $display("FAIL overrun_pending: got %b expected 1", flip_pending); end
        ss_end();
        pulse_frame_start();
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL overrun_flip_rd: got %b expected 0", rd_bank); end
        n_checks++; if (wr_bank !== 1'b1) begin n_fail++; $display("FAIL overrun_flip_wr: got %b expected 1", wr_bank); end
        n_checks++; if (flip_pending !== 1'b0) begin n_fail++; $display("FAIL overrun_flip_pending: got %b expected 0", flip_pending); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        ss_begin();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
        ss_end();
    endtask

    task automatic test_coincident_flip();
        wq.delete();
        ss_begin();
        for (int i = 0; i < TB_PIXELS - 1; i++) send_bits(16'h3000 + 16'(i), 16);
        send_bits(16'h0C0C, 16);
        // Last strobe lands LATENCY cycles after the final rise; frame_start
        // is held for the following edge, where the frame completes.
        wait_cycles(2);
        frame_start = 1'b1;
        wait_cycles(1);
        frame_start = 1'b0;
        wait_cycles(1);
        n_checks++; if (wq.size() != TB_PIXELS) begin n_fail++; $display("FAIL coinc_count: got %0d writes expected %0d", wq.size(), TB_PIXELS); end
        if (wq.size() >= 1) begin
            n_checks++; if (wq[wq.size()-1].cyc - last_rise_cyc != LATENCY) begin n_fail++; $display("FAIL coinc_alignment: got %0d expected %0d", wq[wq.size()-1].cyc - last_rise_cyc, LATENCY); end
        end
        n_checks++; if (flip_pending !== 1'b1) begin n_fail++; $display("FAIL coinc_pending: got %b expected 1", flip_pending); end
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL coinc_no_flip: got %b expected 0", rd_bank); end
        ss_end();
        pulse_frame_start();
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL coinc_later_flip_rd: got %b expected 1", rd_bank); end
        n_checks++; if (wr_bank !== 1'b0) begin n_fail++; $display("FAIL coinc_later_flip_wr: got %b expected 0", wr_bank); end
        n_checks++; if (flip_pending !== 1'b0) begin n_fail++; $display("FAIL coinc_later_pending: got %b expected 0", flip_pending); end
    endtask

    task automatic test_reset_mid_word();
        wq.delete();
        ss_begin();
        send_bits(16'h1111, 16);
        send_bits(16'h2222, 16);
        send_bits(16'hFFFF, 7);
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(2);
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en: got %b expected 0", wr_en); end
        n_checks++; if (wr_addr !== 5'd0) begin n_fail++; $display("FAIL midrst_wr_addr: got %0h expected 0", wr_addr); end
        n_checks++; if (wr_data !== 16'h0000) begin n_fail++; $display("FAIL midrst_wr_data: got %h expected 0000", wr_data); end
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_bank: got %b expected 0", rd_bank); end
        n_checks++; if (wr_bank !== 1'b1) begin n_fail++; $display("FAIL midrst_wr_bank: got %b expected 1", wr_bank); end
        n_checks++; if (flip_pending !== 1'b0) begin n_fail++; $display("FAIL midrst_pending: got %b expected 0", flip_pending); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
        spi_ss_n = 1'b1;
        spi_clk  = 1'b0;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(6);
        n_checks++; if (wq.size() != 2) begin n_fail++; $display("FAIL midrst_pre_count: got %0d writes expected 2", wq.size()); end
        wq.delete();
        ss_begin();
        send_bits(16'h5A5A, 16);
        ss_end();
        n_checks++; if (wq.size() != 1) begin n_fail++; $display("FAIL midrst_post_count: got %0d writes expected 1", wq.size()); end
        if (wq.size() >= 1) begin
            n_checks++; if (wq[0].addr !== 5'd0) begin n_fail++; $display("FAIL midrst_post_addr: got %0h expected 0", wq[0].addr); end
            n_checks++; if (wq[0].data !== 16'h5A5A) begin n_fail++; $display("FAIL midrst_post_data: got %h expected 5a5a", wq[0].data); end
            n_checks++; if (wq[0].bank !== 1'b1) begin n_fail++; $display("FAIL midrst_post_bank: got %b expected 1", wq[0].bank); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_frame();
        test_partial_word();
        test_overrun();
        test_coincident_flip();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
